regfile_write_queue: RTL and testbench
======================================

// Module: regfile_write_queue
// PURPOSE
//  Port controller in front of the register array built from 4-bit register slices.
//  Buffers write-back requests in a small FIFO and drains one per cycle.
//  Drives the one-hot WriteReg lines and the D bus, and decodes the two read-port
//  addresses into one-hot ReadEnable lines.
//  Returns read data with bypass from queued, not-yet-written entries, so the core
//  sees read-after-write coherence.
// PARAMETERS
//  NUM_REGS  16  number of architectural registers; register 0 reads as zero and is not writable
//  ADDR_W    4   register address width, log2(NUM_REGS)
//  DATA_W    16  register width; the register array is built from 4-bit slices
//  QDEPTH    2   write-queue depth, >=1
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         asynchronous reset, active-high
//  wr_valid   in   1         write request valid
//  wr_ready   out  1         queue can accept a request this cycle
//  wr_addr    in   ADDR_W    destination register
//  wr_data    in   DATA_W    write data
//  hold       in   1         stall draining; queue keeps its contents
//  rd_en      in   1         read ports active
//  rd_addr1   in   ADDR_W    read port 1 address
//  rd_addr2   in   ADDR_W    read port 2 address
//  write_reg  out  NUM_REGS  one-hot WriteReg to the register array
//  reg_d      out  DATA_W    D bus to the register array
//  read_en1   out  NUM_REGS  one-hot ReadEnable1
//  read_en2   out  NUM_REGS  one-hot ReadEnable2
//  bitline1   in   DATA_W    Bitline1 from the array
//  bitline2   in   DATA_W    Bitline2 from the array
//  rd_data1   out  DATA_W    port 1 result, after bypass
//  rd_data2   out  DATA_W    port 2 result, after bypass
//  pending    out  $clog2(QDEPTH+1)  number of occupied queue entries
// BEHAVIOUR
//  Reset (async, rst=1): queue empty, pending=0, wr_ready=1, write_reg=0, reg_d=0.
//  Pending writes are discarded on reset, including a reset mid-drain.
//  Push: on a clk edge with wr_valid && wr_ready, the entry {addr,data} enters at the tail.
//  wr_ready = (pending < QDEPTH) || pop_this_cycle, so a full queue accepts while draining.
//  Push while not ready: ignored; the queue is unchanged.
//  Pop: when pending>0 && !hold, the head drives write_reg = onehot(head.addr) and
//  reg_d = head.data. The array captures the value on the same edge that pops the head.
//  Write latency: a request accepted at edge N is written at edge N+1 at the earliest
//  (empty queue, hold=0).
//  Head addr==0: popped normally, but write_reg stays all-zero.
//  Empty queue or hold=1: write_reg=0 and reg_d=0.
//  Push and pop on the same edge: pending is unchanged; FIFO order is preserved.
//  Pointers wrap modulo QDEPTH.
//  Read decode (combinational):
//   - read_enX = onehot(rd_addrX) when rd_en && rd_addrX!=0, else 0.
//   - Never more than one enable is high per port.
//  Read data (combinational):
//   - rd_addrX==0 or rd_en=0 -> 0.
//   - Otherwise, if any occupied entry (head included) matches rd_addrX, the data of the
//     youngest match.
//   - Otherwise bitlineX.
//  Bypass does not include the wr_data being pushed in the same cycle.
//  Both ports may read the same address. A port may read the address currently being
//  written; it gets the bypassed head data.
// TESTING
//  rst pulse mid-cycle with 2 entries queued -> pending=0, write_reg=0, wr_ready=1 immediately; entries never written.
//  push R3=0xBEEF, empty queue, hold=0 -> next cycle write_reg=16'h0008, reg_d=0xBEEF; pending back to 0 after that edge.
//  hold=1, push R5=0x1111 then R5=0x2222 -> pending=2, wr_ready=0; read R5 returns 0x2222 with read_en1=16'h0020; third push ignored.
//  release hold with queue full, push R7=0x7777 the same cycle -> accepted; R5 writes drain in order 0x1111, 0x2222, then R7.
//  push R0=0xFFFF -> entry pops, write_reg stays 0; rd_addr1=0 returns 0 with read_en1=0.
//  rd_en=1, rd_addr1=2, rd_addr2=9, queue empty, bitline1=0x00A5, bitline2=0x5A00 -> rd_data1=0x00A5, rd_data2=0x5A00, read_en2=16'h0200.

Source files
------------

// File: rtl/regfile_write_queue.sv
// Write-back queue and port controller for a register array of 4-bit slices.
// Buffers writes, drains one per cycle, decodes read ports, bypasses queued data.
//
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   wr_valid/ready      write request handshake; wr_addr/wr_data payload
//   hold                stalls draining, queue contents kept
//   rd_en, rd_addr1/2   read port enable and addresses
//   write_reg, reg_d    one-hot WriteReg lines and D bus to the array
//   read_en1/2          one-hot ReadEnable lines to the array
//   bitline1/2          raw read data from the array
//   rd_data1/2          read results after bypass
//   pending             occupied queue entries
module regfile_write_queue #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16,
  parameter int QDEPTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          hold,
  input  logic                          rd_en,
  input  logic [ADDR_W-1:0]             rd_addr1,
  input  logic [ADDR_W-1:0]             rd_addr2,
  output logic [NUM_REGS-1:0]           write_reg,
  output logic [DATA_W-1:0]             reg_d,
  output logic [NUM_REGS-1:0]           read_en1,
  output logic [NUM_REGS-1:0]           read_en2,
  input  logic [DATA_W-1:0]             bitline1,
  input  logic [DATA_W-1:0]             bitline2,
  output logic [DATA_W-1:0]             rd_data1,
  output logic [DATA_W-1:0]             rd_data2,
  output logic [$clog2(QDEPTH+1)-1:0]   pending
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);

  logic [ADDR_W-1:0] addr_q [QDEPTH];
  logic [ADDR_W-1:0] addr_d [QDEPTH];
  logic [DATA_W-1:0] data_q [QDEPTH];
  logic [DATA_W-1:0] data_d [QDEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    if (p == PTR_W'(QDEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // A full queue still accepts when the head leaves on the same edge.
  always_comb begin
    pop      = (count_q != '0) && !hold;
    wr_ready = (count_q < CNT_W'(QDEPTH)) || pop;
    push     = wr_valid && wr_ready;
  end

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    head_d = head_q;
    tail_d = tail_q;
    if (push) begin
      addr_d[tail_q] = wr_addr;
      data_d[tail_q] = wr_data;
      tail_d         = ptr_inc(tail_q);
    end
    if (pop) begin
      head_d = ptr_inc(head_q);
    end
  end

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign pending = count_q;

  // Register 0 is hardwired: its entry still pops, but no line fires.
  always_comb begin
    write_reg = '0;
    reg_d     = '0;
    if (pop) begin
      reg_d = data_q[head_q];
      if (addr_q[head_q] != '0) begin
        write_reg = ONE << addr_q[head_q];
      end
    end
  end

  always_comb begin
    read_en1 = '0;
    read_en2 = '0;
    if (rd_en && rd_addr1 != '0) begin
      read_en1 = ONE << rd_addr1;
    end
    if (rd_en && rd_addr2 != '0) begin
      read_en2 = ONE << rd_addr2;
    end
  end

  // Walk occupied entries oldest to youngest; the last hit wins.
  logic [PTR_W:0]   slot_sum;
  logic [PTR_W-1:0] slot;

  always_comb begin
    rd_data1 = bitline1;
    rd_data2 = bitline2;
    slot_sum = '0;
    slot     = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      slot_sum = {1'b0, head_q} + (PTR_W + 1)'(i);
      if (slot_sum >= (PTR_W + 1)'(QDEPTH)) begin
        slot_sum = slot_sum - (PTR_W + 1)'(QDEPTH);
      end
      slot = slot_sum[PTR_W-1:0];
      if (CNT_W'(i) < count_q) begin
        if (addr_q[slot] == rd_addr1) begin
          rd_data1 = data_q[slot];
        end
        if (addr_q[slot] == rd_addr2) begin
          rd_data2 = data_q[slot];
        end
      end
    end
    if (!rd_en || rd_addr1 == '0) begin
      rd_data1 = '0;
    end
    if (!rd_en || rd_addr2 == '0) begin
      rd_data2 = '0;
    end
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed vector bench for regfile_write_queue.
// Table of per-cycle vectors plus hand-written reset sequences.
module tb_regfile_write_queue;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        hold;
  logic        rd_en;
  logic [3:0]  rd_addr1;
  logic [3:0]  rd_addr2;
  logic [15:0] write_reg;
  logic [15:0] reg_d;
  logic [15:0] read_en1;
  logic [15:0] read_en2;
  logic [15:0] bitline1;
  logic [15:0] bitline2;
  logic [15:0] rd_data1;
  logic [15:0] rd_data2;
  logic [1:0]  pending;

  regfile_write_queue dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .hold     (hold),
    .rd_en    (rd_en),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .write_reg(write_reg),
    .reg_d    (reg_d),
    .read_en1 (read_en1),
    .read_en2 (read_en2),
    .bitline1 (bitline1),
    .bitline2 (bitline2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wv;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        hl;
    logic        re;
    logic [3:0]  a1;
    logic [3:0]  a2;
    logic [15:0] b1;
    logic [15:0] b2;
    logic        e_rdy;
    logic [15:0] e_wreg;
    logic [15:0] e_d;
    logic [15:0] e_re1;
    logic [15:0] e_re2;
    logic [15:0] e_r1;
    logic [15:0] e_r2;
    logic [1:0]  e_pend;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  int passed;
  int total;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    wr_valid = v.wv;
    wr_addr  = v.wa;
    wr_data  = v.wd;
    hold     = v.hl;
    rd_en    = v.re;
    rd_addr1 = v.a1;
    rd_addr2 = v.a2;
    bitline1 = v.b1;
    bitline2 = v.b2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_valid = 1'b0;
    wr_addr  = 4'd0;
    wr_data  = 16'h0;
    hold     = 1'b0;
    rd_en    = 1'b0;
    rd_addr1 = 4'd0;
    rd_addr2 = 4'd0;
    bitline1 = 16'h0;
    bitline2 = 16'h0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    // fields: wv wa wd hold rd_en a1 a2 b1 b2 |
    //         rdy wreg d re1 re2 r1 r2 pend
    tbl[0]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 4'd2, 4'd9,
                16'h00A5, 16'h5A00, 1'b1, 16'h0000, 16'h0000,
                16'h0004, 16'h0200, 16'h00A5, 16'h5A00, 2'd0};
    tbl[1]  = '{1'b1, 4'd3, 16'hBEEF, 1'b0, 1'b0, 4'd0, 4'd0,
                16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'd0};
    tbl[2]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 4'd3, 4'd0,
                16'h1234, 16'h0000, 1'b1, 16'h0008, 16'hBEEF,
                16'h0008, 16'h0000, 16'hBEEF, 16'h0000, 2'd1};
    tbl[3]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 4'd3, 4'd0,
                16'h1234, 16'h0000, 1'b1, 16'h0000, 16'h0000,
                16'h0008, 16'h0000, 16'h1234, 16'h0000, 2'd0};
    tbl[4]  = '{1'b1, 4'd5, 16'h1111, 1'b1, 1'b0, 4'd0, 4'd0,
                16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'd0};
    tbl[5]  = '{1'b1, 4'd5, 16'h2222, 1'b1, 1'b1, 4'd5, 4'd0,
                16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000,
                16'h0020, 16'h0000, 16'h1111, 16'h0000, 2'd1};
    tbl[6]  = '{1'b1, 4'd6, 16'h3333, 1'b1, 1'b1, 4'd5, 4'd6,
                16'h0000, 16'hABCD, 1'b0, 16'h0000, 16'h0000,
                16'h0020, 16'h0040, 16'h2222, 16'hABCD, 2'd2};
    tbl[7]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 4'd5, 4'd6,
                16'h0000, 16'hABCD, 1'b0, 16'h0000, 16'h0000,
                16'h0020, 16'h0040, 16'h2222, 16'hABCD, 2'd2};
    tbl[8]  = '{1'b1, 4'd7, 16'h7777, 1'b0, 1'b1, 4'd7, 4'd5,
                16'h0007, 16'h0000, 1'b1, 16'h0020, 16'h1111,
                16'h0080, 16'h0020, 16'h0007, 16'h2222, 2'd2};
    tbl[9]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 4'd7, 4'd5,
                16'h0000, 16'h0000, 1'b1, 16'h0020, 16'h2222,
                16'h0080, 16'h0020, 16'h7777, 16'h2222, 2'd2};
    tbl[10] = '{1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0, 4'd0,
                16'h0000, 16'h0000, 1'b1, 16'h0080, 16'h7777,
                16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'd1};
    tbl[11] = '{1'b1, 4'd0, 16'hFFFF, 1'b0, 1'b0, 4'd0, 4'd0,
                16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'd0};
    tbl[12] = '{1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 4'd0, 4'd0,
                16'h1111, 16'h2222, 1'b1, 16'h0000, 16'hFFFF,
                16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'd1};
    tbl[13] = '{1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 4'd0, 4'd4,
                16'h0000, 16'h4444, 1'b1, 16'h0000, 16'h0000,
                16'h0000, 16'h0010, 16'h0000, 16'h4444, 2'd0};

    idle();
    rst = 1'b1;
    step();
    step();
    chk("reset pending", 32'(pending), 32'd0);
    chk("reset wr_ready", 32'(wr_ready), 32'd1);
    chk("reset write_reg", 32'(write_reg), 32'h0);
    chk("reset reg_d", 32'(reg_d), 32'h0);
    rst = 1'b0;
    step();

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d wr_ready", i), 32'(wr_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d write_reg", i), 32'(write_reg), 32'(tbl[i].e_wreg));
      chk($sformatf("v%0d reg_d", i), 32'(reg_d), 32'(tbl[i].e_d));
      chk($sformatf("v%0d read_en1", i), 32'(read_en1), 32'(tbl[i].e_re1));
      chk($sformatf("v%0d read_en2", i), 32'(read_en2), 32'(tbl[i].e_re2));
      chk($sformatf("v%0d rd_data1", i), 32'(rd_data1), 32'(tbl[i].e_r1));
      chk($sformatf("v%0d rd_data2", i), 32'(rd_data2), 32'(tbl[i].e_r2));
      chk($sformatf("v%0d pending", i), 32'(pending), 32'(tbl[i].e_pend));
      step();
    end

    // Reset mid-cycle with two held entries queued.
    idle();
    hold     = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 4'd1;
    wr_data  = 16'hAAAA;
    step();
    wr_addr  = 4'd2;
    wr_data  = 16'hBBBB;
    step();
    wr_valid = 1'b0;
    #1;
    chk("rq pending before", 32'(pending), 32'd2);
    chk("rq ready before", 32'(wr_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("rq pending", 32'(pending), 32'd0);
    chk("rq wr_ready", 32'(wr_ready), 32'd1);
    chk("rq write_reg", 32'(write_reg), 32'h0);
    chk("rq reg_d", 32'(reg_d), 32'h0);
    #1;
    rst      = 1'b0;
    hold     = 1'b0;
    rd_en    = 1'b1;
    rd_addr1 = 4'd1;
    rd_addr2 = 4'd2;
    bitline1 = 16'h0101;
    bitline2 = 16'h0202;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("rq c%0d write_reg", c), 32'(write_reg), 32'h0);
      chk($sformatf("rq c%0d pending", c), 32'(pending), 32'd0);
      chk($sformatf("rq c%0d rd_data1", c), 32'(rd_data1), 32'h0101);
      chk($sformatf("rq c%0d rd_data2", c), 32'(rd_data2), 32'h0202);
    end

    // Reset while the head is being driven onto the array.
    idle();
    wr_valid = 1'b1;
    wr_addr  = 4'd9;
    wr_data  = 16'h9999;
    step();
    wr_valid = 1'b0;
    #1;
    chk("rd write_reg before", 32'(write_reg), 32'h0200);
    chk("rd reg_d before", 32'(reg_d), 32'h9999);
    rst = 1'b1;
    #1;
    chk("rd write_reg", 32'(write_reg), 32'h0);
    chk("rd reg_d", 32'(reg_d), 32'h0);
    chk("rd pending", 32'(pending), 32'd0);
    #1;
    rst = 1'b0;
    step();
    chk("rd after write_reg", 32'(write_reg), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
